core_scheduler: RTL and testbench

//  Per-core control FSM that drives core_state to the fetcher, decoder, LSUs, ALUs and PC_NZP units.

---
 rtl/core_scheduler_pkg.sv | 54 +++++
 rtl/core_scheduler_if.sv | 35 +++
 rtl/core_scheduler_lsu_wait_check.sv | 29 ++
 rtl/core_scheduler.sv | 136 +++++++++++++
 tb/tb_core_scheduler.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/core_scheduler_pkg.sv
// ============================================================================
// Module : core_scheduler_pkg
// Brief  : Core FSM state codes, LSU state codes and shared helpers.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package core_scheduler_pkg;

  localparam logic [2:0] CORE_IDLE    = 3'b000;
  localparam logic [2:0] CORE_FETCH   = 3'b001;
  localparam logic [2:0] CORE_DECODE  = 3'b010;
  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_WAIT    = 3'b100;
  localparam logic [2:0] CORE_EXECUTE = 3'b101;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;
  localparam logic [2:0] CORE_DONE    = 3'b111;

  localparam logic [1:0] LSU_IDLE       = 2'b00;
  localparam logic [1:0] LSU_REQUESTING = 2'b01;
  localparam logic [1:0] LSU_WAITING    = 2'b10;
  localparam logic [1:0] LSU_DONE       = 2'b11;

  localparam logic [15:0] INSTR_COUNT_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = CORE_IDLE,
    ST_FETCH   = CORE_FETCH,
    ST_DECODE  = CORE_DECODE,
    ST_REQUEST = CORE_REQUEST,
    ST_WAIT    = CORE_WAIT,
    ST_EXECUTE = CORE_EXECUTE,
    ST_UPDATE  = CORE_UPDATE,
    ST_DONE    = CORE_DONE
  } core_state_e;

  // An LSU still owes the core a result while requesting or waiting.
  function automatic logic lsu_busy(input logic [1:0] s);
    logic busy;
    case (s)
      LSU_IDLE, LSU_DONE:           busy = 1'b0;
      LSU_REQUESTING, LSU_WAITING:  busy = 1'b1;
      default:                      busy = 1'b0;
    endcase
    return busy;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == INSTR_COUNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/core_scheduler_if.sv
// ============================================================================
// Module : core_scheduler_if
// Brief  : Control/status bundle between a core's scheduler and its neighbours.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface core_scheduler_if #(
  parameter int NUM_THREADS = 4,
  parameter int ADDR_BITS   = 8
);
  logic                                  start;
  logic [NUM_THREADS-1:0]                thread_mask;
  logic                                  decoded_ret;
  logic                                  decoded_mem;
  logic [NUM_THREADS-1:0][1:0]           lsu_state;
  logic [NUM_THREADS-1:0][ADDR_BITS-1:0] current_pc;
  logic [2:0]                            core_state;
  logic [NUM_THREADS-1:0]                active_mask;
  logic                                  done;
  logic                                  diverged;
  logic [15:0]                           instr_count;

  modport master (
    output start, thread_mask, decoded_ret, decoded_mem, lsu_state, current_pc,
    input  core_state, active_mask, done, diverged, instr_count
  );

  modport slave (
    input  start, thread_mask, decoded_ret, decoded_mem, lsu_state, current_pc,
    output core_state, active_mask, done, diverged, instr_count
  );
endinterface

`default_nettype wire

// File: rtl/core_scheduler_lsu_wait_check.sv
// ============================================================================
// Module : core_scheduler_lsu_wait_check
// Brief  : Combinational check that every active thread's LSU is idle or done.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module core_scheduler_lsu_wait_check
  import core_scheduler_pkg::*;
#(
  parameter int NUM_THREADS = 4
) (
  input  logic [NUM_THREADS-1:0][1:0] lsu_state,
  input  logic [NUM_THREADS-1:0]      active_mask,
  output logic                        all_ready
);

  always_comb begin
    all_ready = 1'b1;
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (active_mask[t] && lsu_busy(lsu_state[t])) begin
        all_ready = 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/core_scheduler.sv
// ============================================================================
// Module : core_scheduler
// Brief  : Per-core FSM sequencing one instruction at a time, FETCH..UPDATE.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module core_scheduler
  import core_scheduler_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  parameter int ADDR_BITS   = 8
) (
  input  logic              clk,
  input  logic              reset,
  core_scheduler_if.slave   bus
);

  core_state_e            state_q, state_d;
  logic [NUM_THREADS-1:0] active_mask_q, active_mask_d;
  logic                   done_q, done_d;
  logic                   diverged_q, diverged_d;
  logic [15:0]            instr_count_q, instr_count_d;

  logic                   all_ready;
  logic                   pc_mismatch;
  logic                   ref_found;
  logic [ADDR_BITS-1:0]   ref_pc;

  core_scheduler_lsu_wait_check #(
    .NUM_THREADS (NUM_THREADS)
  ) u_wait_check (
    .lsu_state   (bus.lsu_state),
    .active_mask (active_mask_q),
    .all_ready   (all_ready)
  );

  // The lowest-index active thread is the reference PC for divergence.
  always_comb begin
    ref_pc      = '0;
    ref_found   = 1'b0;
    pc_mismatch = 1'b0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (active_mask_q[t]) begin
        if (!ref_found) begin
          ref_pc    = bus.current_pc[t];
          ref_found = 1'b1;
        end else if (bus.current_pc[t] != ref_pc) begin
          pc_mismatch = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    active_mask_d = active_mask_q;
    done_d        = done_q;
    diverged_d    = diverged_q;
    instr_count_d = instr_count_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          active_mask_d = bus.thread_mask;
          instr_count_d = '0;
          diverged_d    = 1'b0;
          done_d        = 1'b0;
          if (bus.thread_mask == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH:   state_d = ST_DECODE;
      ST_DECODE:  state_d = ST_REQUEST;
      ST_REQUEST: state_d = ST_WAIT;
      // WAIT is always entered for at least one cycle, even for non-memory ops.
      ST_WAIT: begin
        if (all_ready) begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: state_d = ST_UPDATE;
      ST_UPDATE: begin
        instr_count_d = sat_inc16(instr_count_q);
        if (pc_mismatch) begin
          diverged_d = 1'b1;
        end
        if (bus.decoded_ret) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DONE: begin
        if (!bus.start) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      active_mask_q <= '0;
      done_q        <= 1'b0;
      diverged_q    <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      active_mask_q <= active_mask_d;
      done_q        <= done_d;
      diverged_q    <= diverged_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign bus.core_state  = state_q;
  assign bus.active_mask = active_mask_q;
  assign bus.done        = done_q;
  assign bus.diverged    = diverged_q;
  assign bus.instr_count = instr_count_q;

endmodule

`default_nettype wire

// File: tb/tb_core_scheduler.sv
// ============================================================================
// Module : tb_core_scheduler
// Brief  : Table-driven, scoreboarded bench for core_scheduler.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_core_scheduler;

  typedef struct packed {
    logic [2:0]  state;
    logic        done;
    logic        div;
    logic [3:0]  mask;
    logic [15:0] cnt;
  } out_t;

  typedef struct packed {
    logic        start;
    logic [3:0]  mask;
    logic        ret;
    logic        mem;
    logic [7:0]  lsu;
    logic [31:0] pc;
    out_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  core_scheduler_if #(.NUM_THREADS(4), .ADDR_BITS(8)) bus ();

  core_scheduler #(
    .NUM_THREADS (4),
    .ADDR_BITS   (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_bad = 0;
  out_t sb[$];
  vec_t vecs[$];

  function automatic out_t mo(input logic [2:0] st, input logic d, input logic dv,
                              input logic [3:0] m, input logic [15:0] c);
    out_t o;
    o.state = st; o.done = d; o.div = dv; o.mask = m; o.cnt = c;
    return o;
  endfunction

  function automatic vec_t mk(input logic s, input logic [3:0] m, input logic r,
                              input logic me, input logic [7:0] l, input logic [31:0] p,
                              input out_t e);
    vec_t v;
    v.start = s; v.mask = m; v.ret = r; v.mem = me; v.lsu = l; v.pc = p; v.exp = e;
    return v;
  endfunction

  function automatic out_t sample();
    out_t o;
    o = {bus.core_state, bus.done, bus.diverged, bus.active_mask, bus.instr_count};
    return o;
  endfunction

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = sample();
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got state=%0d done=%0b div=%0b mask=%h cnt=%0d, want state=%0d done=%0b div=%0b mask=%h cnt=%0d",
               name, act.state, act.done, act.div, act.mask, act.cnt,
               exp.state, exp.done, exp.div, exp.mask, exp.cnt);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, compare after the edge.
  task automatic step(input vec_t v, input string name);
    bus.start       = v.start;
    bus.thread_mask = v.mask;
    bus.decoded_ret = v.ret;
    bus.decoded_mem = v.mem;
    bus.lsu_state   = v.lsu;
    bus.current_pc  = v.pc;
    sb.push_back(v.exp);
    @(posedge clk);
    #2;
    if (sb.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: scoreboard empty, got none want one entry", name);
    end else begin
      check(name, sb.pop_front());
    end
  endtask

  // Body of one instruction with ready LSUs: DECODE, REQUEST, WAIT, EXECUTE, UPDATE.
  task automatic add_walk(input logic [3:0] m, input logic [7:0] l, input logic [31:0] p,
                          input logic dv, input logic [15:0] c);
    for (int s = 2; s <= 6; s++) begin
      vecs.push_back(mk(1'b0, m, 1'b0, 1'b0, l, p, mo(3'(s), 1'b0, dv, m, c)));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset           = 1'b0;
    bus.start       = 1'b0;
    bus.thread_mask = '0;
    bus.decoded_ret = 1'b0;
    bus.decoded_mem = 1'b0;
    bus.lsu_state   = '0;
    bus.current_pc  = '0;

    // Single-instruction block; start and thread_mask wiggle mid-block.
    vecs.push_back(mk(1, 4'hF, 0, 0, 8'h00, 32'h0, mo(1, 0, 0, 4'hF, 0)));
    vecs.push_back(mk(1, 4'hF, 0, 0, 8'h00, 32'h0, mo(2, 0, 0, 4'hF, 0)));
    vecs.push_back(mk(0, 4'hF, 1, 0, 8'h00, 32'h0, mo(3, 0, 0, 4'hF, 0)));
    vecs.push_back(mk(1, 4'h0, 1, 0, 8'h00, 32'h0, mo(4, 0, 0, 4'hF, 0)));
    vecs.push_back(mk(0, 4'h0, 1, 0, 8'h00, 32'h0, mo(5, 0, 0, 4'hF, 0)));
    vecs.push_back(mk(0, 4'hF, 1, 0, 8'h00, 32'h0, mo(6, 0, 0, 4'hF, 0)));
    vecs.push_back(mk(0, 4'hF, 1, 0, 8'h00, 32'h0, mo(7, 1, 0, 4'hF, 1)));
    vecs.push_back(mk(1, 4'hF, 0, 0, 8'h00, 32'h0, mo(7, 1, 0, 4'hF, 1)));
    vecs.push_back(mk(0, 4'hF, 0, 0, 8'h00, 32'h0, mo(0, 0, 0, 4'hF, 1)));

    // Memory stall: thread2 WAITING for five WAIT cycles, then DONE.
    vecs.push_back(mk(1, 4'hF, 1, 1, 8'hE3, 32'h11111111, mo(1, 0, 0, 4'hF, 0)));
    vecs.push_back(mk(0, 4'hF, 1, 1, 8'hE3, 32'h11111111, mo(2, 0, 0, 4'hF, 0)));
    vecs.push_back(mk(0, 4'hF, 1, 1, 8'hE3, 32'h11111111, mo(3, 0, 0, 4'hF, 0)));
    vecs.push_back(mk(0, 4'hF, 1, 1, 8'hE3, 32'h11111111, mo(4, 0, 0, 4'hF, 0)));
    for (int i = 0; i < 4; i++) begin
      vecs.push_back(mk(0, 4'hF, 1, 1, 8'hE3, 32'h11111111, mo(4, 0, 0, 4'hF, 0)));
    end
    vecs.push_back(mk(0, 4'hF, 1, 1, 8'hF3, 32'h11111111, mo(5, 0, 0, 4'hF, 0)));
    vecs.push_back(mk(0, 4'hF, 1, 1, 8'hF3, 32'h11111111, mo(6, 0, 0, 4'hF, 0)));
    vecs.push_back(mk(0, 4'hF, 1, 1, 8'h00, 32'h11111111, mo(7, 1, 0, 4'hF, 1)));
    vecs.push_back(mk(0, 4'hF, 0, 0, 8'h00, 32'h11111111, mo(0, 0, 0, 4'hF, 1)));

    // Masked thread2 stuck REQUESTING; two instructions, inactive PC differs.
    vecs.push_back(mk(1, 4'hB, 0, 1, 8'h10, 32'h0, mo(1, 0, 0, 4'hB, 0)));
    add_walk(4'hB, 8'h10, 32'h0, 0, 0);
    vecs.push_back(mk(0, 4'hB, 0, 1, 8'h10, 32'h0, mo(1, 0, 0, 4'hB, 1)));
    add_walk(4'hB, 8'h10, 32'h0, 0, 1);
    vecs.push_back(mk(0, 4'hB, 1, 1, 8'h10, 32'h07090707, mo(7, 1, 0, 4'hB, 2)));
    vecs.push_back(mk(0, 4'hB, 0, 0, 8'h10, 32'h0, mo(0, 0, 0, 4'hB, 2)));

    // Divergence is sticky through DONE and IDLE, cleared on relaunch.
    vecs.push_back(mk(1, 4'hF, 0, 0, 8'h00, 32'h05050505, mo(1, 0, 0, 4'hF, 0)));
    add_walk(4'hF, 8'h00, 32'h05050505, 0, 0);
    vecs.push_back(mk(0, 4'hF, 1, 0, 8'h00, 32'h05050605, mo(7, 1, 1, 4'hF, 1)));
    vecs.push_back(mk(1, 4'hF, 0, 0, 8'h00, 32'h05050605, mo(7, 1, 1, 4'hF, 1)));
    vecs.push_back(mk(0, 4'hF, 0, 0, 8'h00, 32'h05050605, mo(0, 0, 1, 4'hF, 1)));
    vecs.push_back(mk(1, 4'hE, 0, 0, 8'h00, 32'h0, mo(1, 0, 0, 4'hE, 0)));
    add_walk(4'hE, 8'h00, 32'h0, 0, 0);
    vecs.push_back(mk(0, 4'hE, 1, 0, 8'h00, 32'h03030301, mo(7, 1, 0, 4'hE, 1)));
    vecs.push_back(mk(0, 4'hE, 0, 0, 8'h00, 32'h0, mo(0, 0, 0, 4'hE, 1)));

    // Empty mask goes straight to DONE.
    vecs.push_back(mk(1, 4'h0, 0, 0, 8'h00, 32'h0, mo(7, 1, 0, 4'h0, 0)));
    vecs.push_back(mk(0, 4'h0, 0, 0, 8'h00, 32'h0, mo(0, 0, 0, 4'h0, 0)));

    repeat (2) @(posedge clk);
    #2;
    check("reset_state", mo(0, 0, 0, 4'h0, 0));
    #2;
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset while stalled in WAIT.
    step(mk(1, 4'hF, 0, 1, 8'h20, 32'h0, mo(1, 0, 0, 4'hF, 0)), "rst_fetch");
    step(mk(0, 4'hF, 0, 1, 8'h20, 32'h0, mo(2, 0, 0, 4'hF, 0)), "rst_decode");
    step(mk(0, 4'hF, 0, 1, 8'h20, 32'h0, mo(3, 0, 0, 4'hF, 0)), "rst_request");
    step(mk(0, 4'hF, 0, 1, 8'h20, 32'h0, mo(4, 0, 0, 4'hF, 0)), "rst_wait");
    step(mk(0, 4'hF, 0, 1, 8'h20, 32'h0, mo(4, 0, 0, 4'hF, 0)), "rst_stall");
    #2;
    reset = 1'b0;
    #1;
    check("reset_in_wait", mo(0, 0, 0, 4'h0, 0));
    bus.start = 1'b1;
    @(posedge clk);
    #2;
    check("reset_held_start", mo(0, 0, 0, 4'h0, 0));
    #2;
    reset = 1'b1;
    step(mk(1, 4'h7, 0, 0, 8'h00, 32'h0, mo(1, 0, 0, 4'h7, 0)), "release_launch");

    // Reset in FETCH, release with start low: no launch.
    #2;
    reset = 1'b0;
    #1;
    check("reset_in_fetch", mo(0, 0, 0, 4'h0, 0));
    bus.start = 1'b0;
    #2;
    reset = 1'b1;
    step(mk(0, 4'hF, 0, 0, 8'h00, 32'h0, mo(0, 0, 0, 4'h0, 0)), "idle_no_start");

    // Reset while DONE drops done immediately.
    step(mk(1, 4'h0, 0, 0, 8'h00, 32'h0, mo(7, 1, 0, 4'h0, 0)), "empty_done");
    #2;
    reset = 1'b0;
    #1;
    check("reset_in_done", mo(0, 0, 0, 4'h0, 0));
    #2;
    reset = 1'b1;

    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
